// File: rtl/saida_dados_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : saida_dados_pkg
//  Purpose  : Shared types and constants for the PIO output arbiter family.
//             Holds the controller state encoding, the PIO register address
//             and the data/grant/counter widths.
//  Revision : 1.0  initial release
// ============================================================================
package saida_dados_pkg;

   localparam int          PIO_DATA_W    = 32;
   localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
   localparam int          GRANT_ID_W    = 3;
   localparam int          HOLD_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage : saida_dados_pkg
`default_nettype wire

// File: rtl/saida_dados_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : saida_dados_arbiter_if
//  Purpose  : Bundles the requester handshake, the Avalon-MM PIO write bus
//             and the arbiter status outputs.
//  Ports    : req_valid/req_data   requester -> arbiter
//             req_ready            arbiter -> requester (one-hot accept)
//             pio_*                arbiter -> PIO slave
//             grant_id/busy/write_done  arbiter status
//  Modports : master = arbiter side, slave = requesters + PIO side
//  Revision : 1.0  initial release
// ============================================================================
interface saida_dados_arbiter_if #(
   parameter int N_REQ = 4
);
   import saida_dados_pkg::*;

   logic [N_REQ-1:0]            req_valid;
   logic [PIO_DATA_W*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic [1:0]                  pio_address;
   logic                        pio_chipselect;
   logic                        pio_write_n;
   logic [PIO_DATA_W-1:0]       pio_writedata;
   logic [GRANT_ID_W-1:0]       grant_id;
   logic                        busy;
   logic                        write_done;

   modport master (
      input  req_valid, req_data,
      output req_ready, pio_address, pio_chipselect, pio_write_n,
             pio_writedata, grant_id, busy, write_done
   );

   modport slave (
      output req_valid, req_data,
      input  req_ready, pio_address, pio_chipselect, pio_write_n,
             pio_writedata, grant_id, busy, write_done
   );

endinterface : saida_dados_arbiter_if
`default_nettype wire

// File: rtl/saida_dados_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Searches indices last+1 ..
//             last+N_REQ (mod N_REQ) and returns the first valid one.
//  Ports    : i_valid  N_REQ request bits
//             i_last   index granted most recently
//             o_grant  one-hot grant (all zero if nothing valid)
//             o_idx    index of the granted requester
//             o_any    at least one request valid
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0] i_last,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_cand;

   // Walk from the farthest candidate to the nearest so that the nearest
   // valid requester after i_last is the final (winning) assignment.
   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_cand = IDX_W'((int'(i_last) + k) % N_REQ);
         if (i_valid[w_cand]) begin
            o_idx = w_cand;
            o_any = 1'b1;
         end
      end
   end

   assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/saida_dados_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : saida_dados_arbiter
//  Purpose  : Shares the 32-bit output PIO between N_REQ requesters. Grants
//             round-robin, issues one PIO register-0 write per grant, then
//             holds the value for HOLD_CYCLES before the next grant.
//             Optionally clears the PIO once after reset.
//  Ports    : clk    system clock
//             reset  synchronous active-high reset
//             bus    saida_dados_arbiter_if.master (requesters, PIO, status)
//  Revision : 1.0  initial release
// ============================================================================
module saida_dados_arbiter
   import saida_dados_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   saida_dados_arbiter_if.master bus
);

   localparam int                    c_IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam bit                    c_HAS_HOLD    = (HOLD_CYCLES > 0);
   localparam logic [HOLD_CNT_W-1:0] c_HOLD_LOAD   = HOLD_CNT_W'(c_HAS_HOLD ? HOLD_CYCLES - 1 : 0);
   localparam state_t                c_RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
   localparam logic [c_IDX_W-1:0]    c_LAST_RESET  = c_IDX_W'(N_REQ - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_IDX_W-1:0]    r_last;
   logic [c_IDX_W-1:0]    w_win_idx;
   logic [N_REQ-1:0]      w_win_onehot;
   logic                  w_win_any;
   logic [PIO_DATA_W-1:0] w_win_data;
   logic [PIO_DATA_W-1:0] r_writedata;
   logic [GRANT_ID_W-1:0] r_grant_id;
   logic                  r_write_done;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic                  w_take;
   logic                  w_write_cycle;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (c_IDX_W)
   ) u_rr_arbiter (
      .i_valid (bus.req_valid),
      .i_last  (r_last),
      .o_grant (w_win_onehot),
      .o_idx   (w_win_idx),
      .o_any   (w_win_any)
   );

   // Select the winner's data word.
   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_win_idx == c_IDX_W'(i)) begin
            w_win_data = bus.req_data[PIO_DATA_W*i +: PIO_DATA_W];
         end
      end
   end

   // Next-state and control decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_take        = 1'b0;
      w_write_cycle = 1'b0;
      case (r_state)
         ST_INIT: begin
            // Clear write: writedata is still at its reset value of zero.
            w_write_cycle = 1'b1;
            w_state_nxt   = c_HAS_HOLD ? ST_HOLD : ST_IDLE;
         end
         ST_IDLE: begin
            if (w_win_any) begin
               w_take      = 1'b1;
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_write_cycle = 1'b1;
            w_state_nxt   = c_HAS_HOLD ? ST_HOLD : ST_IDLE;
         end
         ST_HOLD: begin
            if (r_hold_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= c_RESET_STATE;
         r_last       <= c_LAST_RESET;
         r_writedata  <= '0;
         r_grant_id   <= '0;
         r_write_done <= 1'b0;
         r_hold_cnt   <= c_HOLD_LOAD;
      end else begin
         r_state      <= w_state_nxt;
         r_write_done <= w_write_cycle;
         if (w_take) begin
            r_writedata <= w_win_data;
            r_grant_id  <= GRANT_ID_W'(w_win_idx);
            r_last      <= w_win_idx;
         end
         // Counter sits preloaded outside HOLD so it is ready on entry.
         if (r_state != ST_HOLD) begin
            r_hold_cnt <= c_HOLD_LOAD;
         end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
         end
      end
   end

   // Combinational outputs are masked while reset is held: the state register
   // already sits at INIT then, but the clear write must only happen once
   // reset has been released.
   assign bus.req_ready      = (w_take && !reset) ? w_win_onehot : '0;
   assign bus.pio_chipselect = w_write_cycle & ~reset;
   assign bus.pio_write_n    = ~(w_write_cycle & ~reset);
   assign bus.pio_address    = PIO_DATA_ADDR;
   assign bus.pio_writedata  = r_writedata;
   assign bus.grant_id       = r_grant_id;
   assign bus.busy           = (r_state != ST_IDLE) & ~reset;
   assign bus.write_done     = r_write_done;

endmodule : saida_dados_arbiter
`default_nettype wire
